// File: rtl/seq_sync_detect_if.sv
// Stream, control and status bundle for seq_sync_detect.
// miss_cnt exists only when SEQ_DET_MISS_CNT_EN is defined.
interface seq_sync_detect_if #(
    parameter int CNT_W = 16
);
    logic             seq_in;
    logic             seq_vld;
    logic             clr;
    logic             match;
    logic             locked;
    logic [1:0]       state;
    logic [CNT_W-1:0] match_cnt;
`ifdef SEQ_DET_MISS_CNT_EN
    logic [CNT_W-1:0] miss_cnt;
`endif

    modport master (
        output seq_in, seq_vld, clr,
`ifdef SEQ_DET_MISS_CNT_EN
        input  miss_cnt,
`endif
        input  match, locked, state, match_cnt
    );

    modport slave (
        input  seq_in, seq_vld, clr,
`ifdef SEQ_DET_MISS_CNT_EN
        output miss_cnt,
`endif
        output match, locked, state, match_cnt
    );
endinterface

// File: rtl/seq_sync_detect.sv
// Serial pattern detector with HUNT/CHECK/LOCK frame-sync tracking and saturating hit statistics.
// Define SEQ_DET_MISS_CNT_EN to build the aligned-miss counter and its miss_cnt port.
module seq_sync_detect #(
    parameter int               PAT_W    = 8,
    parameter logic [PAT_W-1:0] PATTERN  = 8'b0001_0111,
    parameter int               PERIOD   = 8,
    parameter int               LOCK_N   = 3,
    parameter int               UNLOCK_N = 2,
    parameter int               CNT_W    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_sync_detect_if.slave bus
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam int PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam int RUN_W  = $clog2(UNLOCK_N + 1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(PERIOD - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_N - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(UNLOCK_N - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-2:0]   sh;
    logic [FILL_W-1:0]  fill;
    logic [PH_W-1:0]    ph;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [PAT_W-1:0]   window;
    logic               hit, boundary, ph_exit, miss_inc;
    logic               match_p1;
    logic [CNT_W-1:0]   match_cnt_q;

    // Stage 0: pattern compare on the incoming beat, guarded until PAT_W bits have arrived
    assign window   = {sh, bus.seq_in};
    assign hit      = bus.seq_vld & (fill >= FILL_LAST) & (window == PATTERN);
    assign boundary = (ph == PH_LAST);

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        run_d    = run_q;
        ph_exit  = 1'b0;
        miss_inc = 1'b0;
        if (bus.seq_vld) begin
            unique case (state_q)
                HUNT: begin
                    if (hit) begin
                        ph_exit = 1'b1;
                        if (LOCK_N == 1) begin
                            state_d = LOCK;
                            run_d   = '0;
                        end else begin
                            state_d = CHECK;
                            good_d  = GOOD_W'(1);
                        end
                    end
                end
                CHECK: begin
                    if (boundary) begin
                        if (!hit) begin
                            state_d  = HUNT;
                            miss_inc = 1'b1;
                        end else if (good_q == GOOD_LAST) begin
                            state_d = LOCK;
                            run_d   = '0;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end
                end
                LOCK: begin
                    if (boundary) begin
                        if (hit) begin
                            run_d = '0;
                        end else begin
                            miss_inc = 1'b1;
                            if (run_q == RUN_LAST) begin
                                state_d = HUNT;
                                run_d   = '0;
                            end else begin
                                run_d = run_q + RUN_W'(1);
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Stage 1: registered match, FSM, phase and shift history all move together
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh       <= '0;
            fill     <= '0;
            ph       <= '0;
            state_q  <= HUNT;
            good_q   <= '0;
            run_q    <= '0;
            match_p1 <= 1'b0;
        end else begin
            match_p1 <= hit;
            if (bus.seq_vld) begin
                sh      <= window[PAT_W-2:0];
                state_q <= state_d;
                good_q  <= good_d;
                run_q   <= run_d;
                if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
                if (ph_exit || boundary) ph <= '0;
                else                     ph <= ph + PH_W'(1);
            end
        end
    end

    // clr takes priority over an increment landing on the same edge
    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr)
            match_cnt_q <= '0;
        else if (hit && (match_cnt_q != CNT_MAX))
            match_cnt_q <= match_cnt_q + CNT_W'(1);
    end

`ifdef SEQ_DET_MISS_CNT_EN
    logic [CNT_W-1:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clr)
            miss_cnt_q <= '0;
        else if (miss_inc && (miss_cnt_q != CNT_MAX))
            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end

    assign bus.miss_cnt = miss_cnt_q;
`else
    logic unused_miss_inc;
    assign unused_miss_inc = miss_inc;
`endif

    assign bus.match     = match_p1;
    assign bus.locked    = (state_q == LOCK);
    assign bus.state     = state_q;
    assign bus.match_cnt = match_cnt_q;
endmodule
